vga_timing_monitor: RTL and testbench
=====================================

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter H_TOTAL, 800, pixel clocks per line.
REQ-002 Parameter H_SYNC_START, 656, recovered X at which vga_h_sync falls.
REQ-003 Parameter H_SYNC_W, 96, vga_h_sync low width in clocks.
REQ-004 Parameter V_TOTAL, 525, lines per frame.
REQ-005 Parameter V_SYNC_START, 490, recovered Y of the line in which vga_v_sync falls.
REQ-006 Parameter V_SYNC_W, 2, vga_v_sync low width in lines.
REQ-007 Parameter H_ACTIVE, 640 and V_ACTIVE, 480, visible area.
REQ-008 Clock and reset: one clock; reset is synchronous and active-low.
REQ-009 clk  in  1  pixel clock; all logic on posedge.
REQ-010 reset  in  1  synchronous active-low reset.
REQ-011 vga_h_sync, vga_v_sync  in  1 each  active-low syncs from the VGA generator.
REQ-012 vgaRed, vgaGreen, vgaBlue  in  3 each  pixel colour.
REQ-013 ProbeX, ProbeY  in  10 each  coordinate to sample.
REQ-014 RxX, RxY  out  10 each  recovered pixel coordinate.
REQ-015 Locked  out  1  high in state LOCKED.
REQ-016 HErr, VErr  out  1 each  one-cycle error pulses.
REQ-017 ErrCount  out  8  saturating error count.
REQ-018 FrameCount  out  8  wrapping count of locked frames.
REQ-019 ProbeColor  out  8  {R[2:0],G[2:0],B[2:1]} of the probed pixel; ProbeValid  out  1  one-cycle capture strobe.

Function
REQ-020 Syncs and colour are registered once on entry; all detection uses registered copies; a falling edge is registered-low while previous-registered-high.
REQ-021 hsync fall: RxX loads H_SYNC_START; otherwise RxX increments, wrapping from H_TOTAL-1 to 0.
REQ-022 RxY increments on each RxX wrap to 0, wrapping from V_TOTAL-1 to 0; on a vsync fall RxY loads V_SYNC_START, overriding any increment in the same cycle.
REQ-023 Line-period counter: clocks between consecutive hsync falls; a value other than H_TOTAL is a line error.
REQ-024 hsync low width other than H_SYNC_W, measured at the rising edge, is a line error.
REQ-025 Line starts between consecutive vsync falls other than V_TOTAL is a frame error; a vsync low width in line starts other than V_SYNC_W is a frame error.
REQ-026 States are SEARCH, H_ACQ, V_ACQ, and LOCKED.
REQ-027 SEARCH: the first hsync fall moves to H_ACQ.
REQ-028 H_ACQ: two consecutive correct line periods move to V_ACQ; a line error stays in H_ACQ and clears the good-line tally.
REQ-029 V_ACQ: the first vsync fall moves to LOCKED; a line error returns to SEARCH.
REQ-030 LOCKED: a line error pulses HErr and returns to SEARCH; a frame error pulses VErr and returns to SEARCH; if both occur in one cycle, both pulse.
REQ-031 Errors are flagged only in LOCKED; ErrCount adds 1 per error cycle and saturates at 255.
REQ-032 FrameCount increments on each vsync fall while LOCKED and wraps 255 to 0.
REQ-033 ProbeValid pulses and ProbeColor loads when all of the following hold: Locked; RxX==ProbeX; RxY==ProbeY; RxX<H_ACTIVE; RxY<V_ACTIVE.
REQ-034 The captured colour is the registered colour of that same cycle; ProbeColor holds its value until the next capture.
REQ-035 The probe logic treats out-of-range ProbeX or ProbeY as never matching.
REQ-036 The latency from a pin edge to the counter update is 2 clocks (input register plus edge register).

Reset
REQ-037 With reset low at posedge, the block resets as follows: state SEARCH; RxX=0; RxY=0; all counters=0; ProbeColor=0; all strobes=0; Locked=0; sync registers=1.
REQ-038 Reset asserted mid-frame overrides all activity in that cycle; lock is reacquired from SEARCH.

Verification
REQ-039 Ideal 800x525 timing (hsync fall at X=656 for 96 clocks, vsync fall at Y=490 for 2 lines) -> Locked after 1 vsync fall; HErr and VErr stay 0 for 3 frames; FrameCount=3.
REQ-040 Probe (100,200) with the generator drawing red 3'b111 at that pixel -> one ProbeValid per frame; ProbeColor=8'hE0.
REQ-041 While locked, one line of 799 clocks -> HErr pulses once, ErrCount=1, Locked drops; with ideal timing thereafter, relock occurs at the next vsync fall.
REQ-042 While locked, a vsync low width of 3 lines -> VErr pulse, Locked=0, ErrCount increments.
REQ-043 Probe (700,10) or (10,500) -> ProbeValid never asserts.
REQ-044 Reset held low for 5 clocks mid-line while locked -> all outputs at reset values; Locked=0 until the next full acquisition.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: recovers the pixel coordinate from the sync inputs and
// checks line and frame timing. It captures the colour at one probe
// coordinate once per frame while the timing is locked.
module vga_timing_monitor #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_W     = 96,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_W     = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  input  logic [2:0] vgaRed,
  input  logic [2:0] vgaGreen,
  input  logic [2:0] vgaBlue,
  input  logic [9:0] ProbeX,
  input  logic [9:0] ProbeY,
  output logic [9:0] RxX,
  output logic [9:0] RxY,
  output logic       Locked,
  output logic       HErr,
  output logic       VErr,
  output logic [7:0] ErrCount,
  output logic [7:0] FrameCount,
  output logic [7:0] ProbeColor,
  output logic       ProbeValid
);

  localparam int CW = 11;

  typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;

  state_t state, state_nxt;

  logic          hs_r, vs_r, hs_p, vs_p;
  logic [7:0]    col_r;
  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic [CW-1:0] line_cnt, hlow_cnt, vline_cnt, vlow_cnt;
  logic          line_err, frame_err;
  logic [1:0]    good_cnt;
  logic          herr_d, verr_d, frame_inc;
  logic          unused_blue_lsb;

  // The blue LSB is not part of the 8-bit captured colour.
  always_comb unused_blue_lsb = vgaBlue[0];

  // Input registers and the previous-value registers used for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      col_r <= '0;
    end else begin
      hs_r  <= vga_h_sync;
      vs_r  <= vga_v_sync;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      col_r <= {vgaRed, vgaGreen, vgaBlue[2:1]};
    end
  end

  // Edge decode and timing-error decode from the registered syncs
  always_comb begin
    hs_fall   = !hs_r && hs_p;
    hs_rise   = hs_r && !hs_p;
    vs_fall   = !vs_r && vs_p;
    vs_rise   = vs_r && !vs_p;
    line_err  = (hs_fall && line_cnt != CW'(H_TOTAL)) ||
                (hs_rise && hlow_cnt != CW'(H_SYNC_W));
    frame_err = (vs_fall && vline_cnt != CW'(V_TOTAL)) ||
                (vs_rise && vlow_cnt != CW'(V_SYNC_W));
  end

  // Recovered coordinate counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      RxX <= '0;
      RxY <= '0;
    end else begin
      if (hs_fall)
        RxX <= 10'(H_SYNC_START);
      else if (RxX == 10'(H_TOTAL - 1))
        RxX <= '0;
      else
        RxX <= RxX + 10'd1;

      if (vs_fall)
        RxY <= 10'(V_SYNC_START);
      else if (!hs_fall && RxX == 10'(H_TOTAL - 1))
        RxY <= (RxY == 10'(V_TOTAL - 1)) ? '0 : RxY + 10'd1;
    end
  end

  // Saturating period and sync-width counters. The vertical counters count
  // line starts; a line start coinciding with the vsync fall opens the new frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_cnt  <= '0;
      hlow_cnt  <= '0;
      vline_cnt <= '0;
      vlow_cnt  <= '0;
    end else begin
      if (hs_fall)
        line_cnt <= CW'(1);
      else if (line_cnt != '1)
        line_cnt <= line_cnt + CW'(1);

      if (hs_fall)
        hlow_cnt <= CW'(1);
      else if (!hs_r && hlow_cnt != '1)
        hlow_cnt <= hlow_cnt + CW'(1);

      if (vs_fall)
        vline_cnt <= hs_fall ? CW'(1) : '0;
      else if (hs_fall && vline_cnt != '1)
        vline_cnt <= vline_cnt + CW'(1);

      if (vs_fall)
        vlow_cnt <= hs_fall ? CW'(1) : '0;
      else if (hs_fall && !vs_r && vlow_cnt != '1)
        vlow_cnt <= vlow_cnt + CW'(1);
    end
  end

  // State register and the good-line tally used during horizontal acquisition
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != H_ACQ || line_err)
        good_cnt <= '0;
      else if (hs_fall)
        good_cnt <= good_cnt + 2'd1;
    end
  end

  // Next-state and error/frame strobes
  always_comb begin
    state_nxt = state;
    herr_d    = 1'b0;
    verr_d    = 1'b0;
    frame_inc = 1'b0;
    case (state)
      SEARCH: if (hs_fall) state_nxt = H_ACQ;
      H_ACQ:  if (hs_fall && !line_err && good_cnt == 2'd1) state_nxt = V_ACQ;
      V_ACQ: begin
        if (line_err)     state_nxt = SEARCH;
        else if (vs_fall) state_nxt = LOCKED;
      end
      LOCKED: begin
        herr_d    = line_err;
        verr_d    = frame_err;
        frame_inc = vs_fall;
        if (line_err || frame_err) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
    Locked = (state == LOCKED);
  end

  // Error pulses, saturating error count and wrapping frame count
  always_ff @(posedge clk) begin
    if (!reset) begin
      HErr       <= 1'b0;
      VErr       <= 1'b0;
      ErrCount   <= '0;
      FrameCount <= '0;
    end else begin
      HErr <= herr_d;
      VErr <= verr_d;
      if ((herr_d || verr_d) && ErrCount != 8'hFF)
        ErrCount <= ErrCount + 8'd1;
      if (frame_inc)
        FrameCount <= FrameCount + 8'd1;
    end
  end

  // Probe capture; the active-area bounds make out-of-range probes never match
  always_ff @(posedge clk) begin
    if (!reset) begin
      ProbeValid <= 1'b0;
      ProbeColor <= '0;
    end else begin
      ProbeValid <= 1'b0;
      if (Locked && RxX == ProbeX && RxY == ProbeY &&
          RxX < 10'(H_ACTIVE) && RxY < 10'(V_ACTIVE)) begin
        ProbeValid <= 1'b1;
        ProbeColor <= col_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down 40x20 raster so that
// many frames fit in a short run. Same structure as 800x525, smaller numbers.
module tb_vga_timing_monitor;

  localparam int HT  = 40;
  localparam int HSS = 30;
  localparam int HSW = 4;
  localparam int VT  = 20;
  localparam int VSS = 16;
  localparam int VSW = 2;
  localparam int HA  = 24;
  localparam int VA  = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_h_sync, vga_v_sync;
  logic [2:0] vgaRed, vgaGreen, vgaBlue;
  logic [9:0] ProbeX, ProbeY;
  logic [9:0] RxX, RxY;
  logic       Locked, HErr, VErr, ProbeValid;
  logic [7:0] ErrCount, FrameCount, ProbeColor;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
    .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
    .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .ProbeX(ProbeX), .ProbeY(ProbeY),
    .RxX(RxX), .RxY(RxY), .Locked(Locked), .HErr(HErr), .VErr(VErr),
    .ErrCount(ErrCount), .FrameCount(FrameCount),
    .ProbeColor(ProbeColor), .ProbeValid(ProbeValid)
  );

  int checks = 0;
  int errors = 0;
  int herr_seen = 0, verr_seen = 0, pv_seen = 0;
  int gx = 0, gy = 0, vs_w = VSW;
  bit short_line = 1'b0;
  int h0, v0, p0;

  // Pulse counters for the one-cycle strobes
  always @(negedge clk) begin
    herr_seen <= herr_seen + int'(HErr);
    verr_seen <= verr_seen + int'(VErr);
    pv_seen   <= pv_seen + int'(ProbeValid);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel of the generator. Red strip on row 5, x 9..12 so the probe at
  // recovered (10,5) sees red; blue everywhere else.
  task automatic tick();
    @(negedge clk);
    vga_h_sync = !(gx >= HSS && gx < HSS + HSW);
    vga_v_sync = !(gy >= VSS && gy < VSS + vs_w);
    if (gy == 5 && gx >= 9 && gx <= 12) {vgaRed, vgaGreen, vgaBlue} = 9'b111_000_000;
    else                                {vgaRed, vgaGreen, vgaBlue} = 9'b000_000_011;
    gx++;
    if (gx == (short_line ? HT - 1 : HT)) begin
      gx = 0;
      short_line = 1'b0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next pixel to be driven is (y,x)
  task automatic run_to(input int y, input int x);
    for (int i = 0; i < 2 * HT * VT && !(gx == x && gy == y); i++) tick();
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_rxx"}, 32'(RxX), 0);
    chk({pfx, "_rxy"}, 32'(RxY), 0);
    chk({pfx, "_locked"}, 32'(Locked), 0);
    chk({pfx, "_herr"}, 32'(HErr), 0);
    chk({pfx, "_verr"}, 32'(VErr), 0);
    chk({pfx, "_errcount"}, 32'(ErrCount), 0);
    chk({pfx, "_framecount"}, 32'(FrameCount), 0);
    chk({pfx, "_probecolor"}, 32'(ProbeColor), 0);
    chk({pfx, "_probevalid"}, 32'(ProbeValid), 0);
  endtask

  initial begin
    reset = 1'b0;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    {vgaRed, vgaGreen, vgaBlue} = '0;
    ProbeX = 10'd10;
    ProbeY = 10'd5;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b1;

    // Acquisition: H_ACQ after line 0, V_ACQ after line 2, lock at vsync fall
    run_to(10, 0);
    chk("prelock_locked", 32'(Locked), 0);
    run_to(17, 10);
    chk("lock_locked", 32'(Locked), 1);
    chk("lock_rxx", 32'(RxX), 7);
    chk("lock_rxy", 32'(RxY), 17);

    // Three clean frames with probe at (10,5)
    h0 = herr_seen; v0 = verr_seen; p0 = pv_seen;
    run(3 * HT * VT);
    chk("ideal_herr", 32'(herr_seen - h0), 0);
    chk("ideal_verr", 32'(verr_seen - v0), 0);
    chk("ideal_framecount", 32'(FrameCount), 3);
    chk("ideal_locked", 32'(Locked), 1);
    chk("probe_valid_per_frame", 32'(pv_seen - p0), 3);
    chk("probe_color", 32'(ProbeColor), 32'hE0);

    // Probes outside the visible area never capture
    ProbeX = 10'd32; ProbeY = 10'd3;
    p0 = pv_seen;
    run(HT * VT);
    chk("probe_x_blank", 32'(pv_seen - p0), 0);
    ProbeX = 10'd3; ProbeY = 10'd17;
    p0 = pv_seen;
    run(HT * VT);
    chk("probe_y_blank", 32'(pv_seen - p0), 0);
    chk("probe_color_hold", 32'(ProbeColor), 32'hE0);
    chk("blank_framecount", 32'(FrameCount), 5);

    // One line one clock short while locked
    run_to(3, 0);
    h0 = herr_seen; v0 = verr_seen;
    short_line = 1'b1;
    run_to(10, 0);
    chk("short_herr", 32'(herr_seen - h0), 1);
    chk("short_verr", 32'(verr_seen - v0), 0);
    chk("short_errcount", 32'(ErrCount), 1);
    chk("short_locked", 32'(Locked), 0);
    run_to(17, 10);
    chk("short_relock", 32'(Locked), 1);
    chk("short_framecount", 32'(FrameCount), 5);

    // Three-line vsync pulse while locked
    run_to(1, 0);
    vs_w = 3;
    h0 = herr_seen; v0 = verr_seen;
    run_to(19, 10);
    vs_w = VSW;
    chk("vwide_verr", 32'(verr_seen - v0), 1);
    chk("vwide_herr", 32'(herr_seen - h0), 0);
    chk("vwide_locked", 32'(Locked), 0);
    chk("vwide_errcount", 32'(ErrCount), 2);
    chk("vwide_framecount", 32'(FrameCount), 6);
    run_to(17, 10);
    chk("vwide_relock", 32'(Locked), 1);

    // Reset for 5 clocks mid-line while locked
    ProbeX = 10'd10; ProbeY = 10'd5;
    run_to(8, 15);
    reset = 1'b0;
    run(5);
    chk_reset_values("midreset");
    reset = 1'b1;
    run_to(15, 0);
    chk("midreset_prelock", 32'(Locked), 0);
    run_to(17, 10);
    chk("midreset_relock", 32'(Locked), 1);
    chk("midreset_rxx", 32'(RxX), 7);
    chk("midreset_rxy", 32'(RxY), 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
